// File: rtl/alu_arbiter.sv
// Two-requester front end for a registered ALU: one operation in flight, IDLE/ISSUE/WAIT/RESP.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; the default is fixed priority (requester 0 wins).
module alu_arbiter (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_enable,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    input  logic [1:0][3:0]  req_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   owner;
    logic   grant;
    logic   accept;
    logic   legal;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic   last_grant;
`endif

    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end

        req_ready = '0;
        if (state == IDLE && clk_enable && !rst && (|req_valid))
            req_ready[grant] = 1'b1;

        accept = |req_ready;
        legal  = (req_op[grant] < 4'hA);
    end

    // The ALU operand registers double as the request latch: loading them at
    // acceptance makes them valid for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                        if (legal) begin
                            alu_a  <= req_a[grant];
                            alu_b  <= req_b[grant];
                            alu_op <= req_op[grant];
                            state  <= ISSUE;
                        end else begin
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= {grant, ~grant};
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    alu_a  <= '0;
                    alu_b  <= '0;
                    alu_op <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    resp_data  <= alu_out;
                    resp_err   <= 1'b0;
                    resp_valid <= {owner, ~owner};
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
    a_resp_onehot:  assert property (@(posedge clk) $onehot0(resp_valid));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU; directed vectors.
module tb_alu_arbiter;

    logic             clk;
    logic             rst;
    logic             clk_enable;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][3:0]  req_op;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_out;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic alu_seen = 1'b0;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a * b;
            4'h3:    return a & b;
            4'h4:    return a ^ b;
            4'h5:    return a | b;
            4'h6:    return a << b[4:0];
            4'h7:    return a >> b[4:0];
            4'h8:    return $signed(a) >>> b[4:0];
            4'h9:    return {31'b0, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (clk_enable) alu_out <= alu_f(alu_a, alu_b, alu_op);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a response completes on the next edge when owner's ready is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (alu_a != 0 || alu_b != 0 || alu_op != 0) alu_seen = 1'b1;
            if (!rst && clk_enable && ((resp_valid & resp_ready) != 2'b00)) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {30'b0, resp_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", {30'b0, resp_valid}, e.owner ? 32'h2 : 32'h1);
                    check("resp_data", resp_data, e.data);
                    check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic owner, input logic [31:0] data, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while ((sb.size() != 0 || resp_valid != 2'b00) && n < 40) begin
            tick();
            n++;
        end
        check(name, {31'b0, (sb.size() == 0 && resp_valid == 2'b00)}, 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        clk_enable = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 2'b11;
        tick();
        tick();
        check("rst_req_ready", {30'b0, req_ready}, 32'h0);
        check("rst_resp_valid", {30'b0, resp_valid}, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_op", {28'b0, alu_op}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic add with latency checks
        req_a[0] = 32'd5; req_b[0] = 32'd7; req_op[0] = 4'h0;
        req_valid = 2'b01;
        push(1'b0, 32'd12, 1'b0);
        #1;
        check("t1_ready_idle", {30'b0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        check("t1_issue_a", alu_a, 32'd5);
        check("t1_issue_b", alu_b, 32'd7);
        check("t1_issue_op", {28'b0, alu_op}, 32'h0);
        check("t1_issue_ready", {30'b0, req_ready}, 32'h0);
        tick();
        check("t1_wait_alu_a", alu_a, 32'h0);
        check("t1_wait_valid", {30'b0, resp_valid}, 32'h0);
        tick();
        check("t1_resp_valid", {30'b0, resp_valid}, 32'h1);
        check("t1_resp_data", resp_data, 32'd12);
        tick();
        check("t1_resp_done", {30'b0, resp_valid}, 32'h0);
        drain("t1_drain");

        // Both requesters continuously valid
        do_reset();
        req_a[0] = 32'd10;   req_b[0] = 32'd3;    req_op[0] = 4'h1;
        req_a[1] = 32'hF0;   req_b[1] = 32'h0F;   req_op[1] = 4'h4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        push(1'b0, 32'd7, 1'b0);
        push(1'b1, 32'hFF, 1'b0);
        push(1'b0, 32'd7, 1'b0);
        push(1'b1, 32'hFF, 1'b0);
`else
        for (int i = 0; i < 4; i++) push(1'b0, 32'd7, 1'b0);
`endif
        req_valid = 2'b11;
        for (int i = 0; i < 13; i++) tick();
        req_valid = '0;
        drain("t2_drain");

        // Illegal op: error response without touching the ALU
        alu_seen = 1'b0;
        req_a[1] = 32'h123; req_b[1] = 32'h456; req_op[1] = 4'hC;
        req_valid = 2'b10;
        push(1'b1, 32'h0, 1'b1);
        tick();
        req_valid = '0;
        check("t3_resp_valid", {30'b0, resp_valid}, 32'h2);
        check("t3_resp_err", {31'b0, resp_err}, 32'h1);
        check("t3_alu_op", {28'b0, alu_op}, 32'h0);
        drain("t3_drain");
        check("t3_alu_idle", {31'b0, alu_seen}, 32'h0);

        // Back-pressure on owner; non-owner ready ignored; req1 waits
        resp_ready = 2'b00;
        req_a[0] = 32'd1;   req_b[0] = 32'd2; req_op[0] = 4'h0;
        req_a[1] = 32'd100; req_b[1] = 32'd1; req_op[1] = 4'h1;
        push(1'b0, 32'd3, 1'b0);
        push(1'b1, 32'd99, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", {30'b0, resp_valid}, 32'h1);
            check("t4_hold_data", resp_data, 32'd3);
            check("t4_hold_ready", {30'b0, req_ready}, 32'h0);
            tick();
        end
        resp_ready = 2'b01;
        tick();
        check("t4_grant_after_hs", {30'b0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        check("t4_req1_issue", alu_a, 32'd100);
        resp_ready = 2'b11;
        drain("t4_drain");

        // clk_enable stalls
        clk_enable = 1'b0;
        req_a[0] = 32'hFFFF_FFFC; req_b[0] = 32'd1; req_op[0] = 4'h2;
        req_valid = 2'b01;
        #1;
        check("t5_ready_disabled", {30'b0, req_ready}, 32'h0);
        tick();
        check("t5_idle_frozen", alu_a, 32'h0);
        clk_enable = 1'b1;
        push(1'b0, 32'hFFFF_FFFC, 1'b0);
        tick();
        req_valid = '0;
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_issue_frozen_a", alu_a, 32'hFFFF_FFFC);
            check("t5_issue_frozen_op", {28'b0, alu_op}, 32'h2);
        end
        clk_enable = 1'b1;
        tick();
        check("t5_wait_alu_a", alu_a, 32'h0);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_wait_frozen", {30'b0, resp_valid}, 32'h0);
        end
        clk_enable = 1'b1;
        tick();
        check("t5_resp_valid", {30'b0, resp_valid}, 32'h1);
        drain("t5_drain");

        // Reset during WAIT abandons the operation
        req_a[0] = 32'd2; req_b[0] = 32'd3; req_op[0] = 4'h0;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", {30'b0, resp_valid}, 32'h0);
        check("t6_rst_alu_a", alu_a, 32'h0);
        check("t6_rst_alu_op", {28'b0, alu_op}, 32'h0);
        req_a[1] = 32'd8; req_b[1] = 32'd9; req_op[1] = 4'h0;
        req_valid = 2'b10;
        push(1'b1, 32'd17, 1'b0);
        #1;
        check("t6_ready_after_rst", {30'b0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        check("t6_new_issue", alu_a, 32'd8);
        drain("t6_drain");

        for (int i = 0; i < 4; i++) tick();
        check("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
